// File: rtl/simmem_pkg.sv
// Shared defaults for the simulated memory controller message bank.
// Widths are derived locally in each module from these parameters.
package simmem_pkg;
    localparam int DefStructWidth   = 10;
    localparam int DefTotalCapacity = 16;
    localparam int DefIdWidth       = 2;
endpackage

// File: rtl/simmem_rr_arbiter.sv
// Round-robin arbiter: search starts at the requester after the last grant.
// The pointer only moves when the grant is actually consumed (advance_i).
module simmem_rr_arbiter
    import simmem_pkg::*;
#(
    parameter int NumReq = 2 ** DefIdWidth
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              advance_i,
    output logic [NumReq-1:0] grant_o
);
    localparam int PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrWidth-1:0] ptr_q;
    logic [PtrWidth-1:0] ptr_next;
    logic [PtrWidth-1:0] idx;

    // Walk offsets from far to near so the nearest requester wins; NumReq is a power of two.
    always_comb begin
        grant_o  = '0;
        ptr_next = ptr_q;
        idx      = '0;
        for (int off = NumReq - 1; off >= 0; off--) begin
            idx = ptr_q + PtrWidth'(off);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                ptr_next     = idx + PtrWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_next;
        end
    end
endmodule

// File: rtl/simmem_linkedlist_bank_rr.sv
// Per-ID FIFO queues kept as linked lists in one shared RAM; released IDs
// drain round-robin through a registered valid/ready output stage.
module simmem_linkedlist_bank_rr
    import simmem_pkg::*;
#(
    parameter int StructWidth   = DefStructWidth,
    parameter int TotalCapacity = DefTotalCapacity,
    parameter int IdWidth       = DefIdWidth,
    localparam int NumIds       = 2 ** IdWidth,
    localparam int CntWidth     = $clog2(TotalCapacity + 1),
    localparam int PtrWidth     = $clog2(TotalCapacity)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumIds-1:0]          release_en_i,
    input  logic [StructWidth-1:0]     data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [StructWidth-1:0]     data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NumIds*CntWidth-1:0] id_count_o,
    output logic [CntWidth-1:0]        free_count_o
);
    function automatic logic [PtrWidth-1:0] lowest_free(input logic [TotalCapacity-1:0] mask);
        lowest_free = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (mask[i]) lowest_free = PtrWidth'(i);
        end
    endfunction

    function automatic logic [IdWidth-1:0] onehot_idx(input logic [NumIds-1:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < NumIds; i++) begin
            if (oh[i]) onehot_idx = IdWidth'(i);
        end
    endfunction

    logic [StructWidth-1:0]   data_ram [TotalCapacity];
    logic [PtrWidth-1:0]      next_ram [TotalCapacity];
    logic [TotalCapacity-1:0] free_mask_q;
    logic [CntWidth-1:0]      free_count_q;
    logic [PtrWidth-1:0]      head_q [NumIds];
    logic [PtrWidth-1:0]      tail_q [NumIds];
    logic [CntWidth-1:0]      count_q [NumIds];
    logic                     out_valid_q;
    logic [StructWidth-1:0]   data_q;

    logic [NumIds-1:0]  eligible;
    logic [NumIds-1:0]  grant;
    logic [NumIds-1:0]  push_hit;
    logic [NumIds-1:0]  pop_hit;
    logic               push;
    logic               load;
    logic [IdWidth-1:0] push_id;
    logic [IdWidth-1:0] gnt_id;
    logic [PtrWidth-1:0] new_slot;
    logic [PtrWidth-1:0] pop_slot;

    assign in_ready_o   = (free_count_q != '0);
    assign free_count_o = free_count_q;
    assign out_valid_o  = out_valid_q;
    assign data_o       = data_q;

    assign push     = in_valid_i && in_ready_o;
    assign push_id  = data_i[IdWidth-1:0];
    assign new_slot = lowest_free(free_mask_q);
    assign gnt_id   = onehot_idx(grant);
    assign pop_slot = head_q[gnt_id];
    assign load     = (!out_valid_q || out_ready_i) && (|eligible);

    always_comb begin
        eligible   = '0;
        push_hit   = '0;
        pop_hit    = '0;
        id_count_o = '0;
        for (int i = 0; i < NumIds; i++) begin
            eligible[i] = release_en_i[i] && (count_q[i] != '0);
            push_hit[i] = push && (push_id == IdWidth'(i));
            pop_hit[i]  = load && grant[i];
            id_count_o[i*CntWidth +: CntWidth] = count_q[i];
        end
    end

    simmem_rr_arbiter #(.NumReq(NumIds)) u_arbiter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (eligible),
        .advance_i (load),
        .grant_o   (grant)
    );

    // Link write into the old tail is harmless even if that tail is popped this cycle.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_ram[new_slot] <= data_i;
            if (count_q[push_id] != '0) next_ram[tail_q[push_id]] <= new_slot;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_mask_q  <= '1;
            free_count_q <= CntWidth'(TotalCapacity);
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            for (int i = 0; i < NumIds; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            if (push) free_mask_q[new_slot] <= 1'b0;
            if (load) free_mask_q[pop_slot] <= 1'b1;
            if (push && !load) free_count_q <= free_count_q - CntWidth'(1);
            else if (load && !push) free_count_q <= free_count_q + CntWidth'(1);

            for (int i = 0; i < NumIds; i++) begin
                if (push_hit[i] && !pop_hit[i]) count_q[i] <= count_q[i] + CntWidth'(1);
                else if (pop_hit[i] && !push_hit[i]) count_q[i] <= count_q[i] - CntWidth'(1);
                if (push_hit[i]) tail_q[i] <= new_slot;
                // Popping the last entry hands the head to a same-cycle push (or leaves it unused).
                if (pop_hit[i]) begin
                    head_q[i] <= (count_q[i] == CntWidth'(1)) ? new_slot : next_ram[head_q[i]];
                end else if (push_hit[i] && count_q[i] == '0) begin
                    head_q[i] <= new_slot;
                end
            end

            if (load) begin
                out_valid_q <= 1'b1;
                data_q      <= data_ram[pop_slot];
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
